draw_bounding_box: RTL
======================

# draw_bounding_box

Consumer of the edge-search results: waits for both the left-edge and right-edge found pulses, latches the shape's four bounds, and streams the rectangle outline as one pixel write per cycle (x, y, colour, plot) toward the VGA/frame-buffer write port. It sits directly after the left/right edge search and pairs with the top/bottom bound outputs that feed that search. It emits a one-cycle `done` pulse when the outline is complete.

## Interface
- `XSZ`, 8, x coordinate width (160-wide screen)
- `YSZ`, 7, y coordinate width
- `COLSZ`, 3, colour width
- `BOX_COLOUR`, 3'b100, colour driven on every plotted pixel
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state and outputs
- `leftFound`  in  1  one-cycle pulse: `mostLeft` valid and stable
- `rightFound`  in  1  one-cycle pulse: `mostRight` valid and stable
- `mostLeft`  in  XSZ  left bound, inclusive
- `mostRight`  in  XSZ  right bound, inclusive
- `mostTop`  in  YSZ  top bound, inclusive; stable before either found pulse
- `mostBottom`  in  YSZ  bottom bound, inclusive; stable before either found pulse
- `x_out`  out  XSZ  pixel x, registered
- `y_out`  out  YSZ  pixel y, registered
- `colour`  out  COLSZ  `BOX_COLOUR` while `plot`=1, else 0
- `plot`  out  1  pixel write strobe, one pixel per cycle
- `busy`  out  1  high from LATCH through the last plotted pixel
- `done`  out  1  one-cycle pulse after the last pixel, or after rejection of invalid bounds

## Operation
- Sticky flags `l_seen` and `r_seen` are set by `leftFound` and `rightFound`. The pulses may arrive in any order and in any cycles, including the same cycle.
- While `busy`=1, found pulses are ignored and do not set the flags.
- States: IDLE → LATCH → TOP → BOTTOM → LEFT → RIGHT → DONE → IDLE.
- IDLE: leave when `l_seen & r_seen`, or when the second pulse arrives. That is, in the cycle after the later pulse.
- LATCH:
  - register L, R, T, B.
  - clear both flags.
  - if L>R or T>B, go to DONE with no pixels plotted.
- TOP: plot (x, T) for x = L..R, ascending.
- BOTTOM: plot (x, B) for x = L..R. Skip this state if B==T.
- LEFT: plot (L, y) for y = T+1..B-1, ascending. Skip this state if B-T<2.
- RIGHT: plot (R, y) for y = T+1..B-1. Skip this state if B-T<2 or L==R.
- Each state owns one counter. The next state is entered on the same edge the counter reaches its end value, so there are no idle cycles between segments.
- Pixel count:
  - 2(R-L+1) + 2(B-T-1) in general.
  - no duplicate pixels for any legal bounds.
- DONE: `done`=1 for one cycle, then return to IDLE. Flags set in this cycle are honoured.
- Arithmetic:
  - counters are XSZ/YSZ wide and unsigned.
  - end comparisons use equality against the latched bound, so there is no wrap at x=159 or y=119.
  - R=2^XSZ-1 must terminate correctly.
- Reset at any time: state goes to IDLE and all flags, latches and outputs go to 0. A partially drawn box is abandoned.

## Timing
- Reset values: `x_out`=0, `y_out`=0, `colour`=0, `plot`=0, `busy`=0, `done`=0.
- The later found pulse in cycle c gives:
  - LATCH in c+1 (`busy`=1).
  - first `plot`=1 with (L, T) in c+2.
  - N pixels in cycles c+2..c+N+1.
  - `done` in c+N+2.
  - `busy`=0 in c+N+2.
- Invalid bounds: `done` in c+2, `plot` never asserted.
- All outputs come from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `bbox_pkg` holds:
  - XSZ/YSZ/COLSZ constants.
  - the state enum (8 codes, 3 bits).
  - the default `BOX_COLOUR`.
- One natural sub-module: `span_counter`.
  - loads a start value, increments while enabled, and flags `last` when count == end.
  - instantiated once for x and once for y, each reused across segments.
- The top module contains the FSM, the sticky flags and the bound latches.

## Test plan
- L=10, R=13, T=5, B=7; `leftFound` at c, `rightFound` at c+3 → 10 pixels in order:
  - (10..13, 5) and (10..13, 7).
  - then (10, 6) and (13, 6).
  - cycles c+5..c+14; `done` at c+15.
- L=20, R=22, T=30, B=30; both pulses in the same cycle c → 3 pixels (20..22, 30), `done` at c+5.
- L=R=5, T=1, B=4 → pixels (5,1), (5,4), (5,2), (5,3); no duplicates; 4 plots total.
- L=40, R=30 (invalid) → `plot` never 1, `done` at c+2, `busy` high only in c+1.
- `leftFound` pulsed again mid-draw → ignored, no redraw after `done`. A fresh pair after `done` → second box drawn.
- `reset` asserted during TOP → next cycle all outputs 0 and IDLE. A following found pair draws a complete box from (L, T).

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared constants and state encoding for the bounding-box outline drawer.
package bbox_pkg;

    // Screen coordinate and colour widths (160x120 display).
    localparam int BBOX_XSZ   = 8;
    localparam int BBOX_YSZ   = 7;
    localparam int BBOX_COLSZ = 3;

    // Colour driven on every plotted outline pixel.
    localparam logic [BBOX_COLSZ-1:0] BBOX_COLOUR = 3'b100;

    // Drawing sequence. The eighth 3-bit code is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_TOP    = 3'd2,
        ST_BOTTOM = 3'd3,
        ST_LEFT   = 3'd4,
        ST_RIGHT  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/draw_bounding_box_span_counter.sv
// Loadable up-counter that walks one outline segment and flags its last value.
module span_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_start,
    input  logic         i_en,
    input  logic [W-1:0] i_end,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    logic [W-1:0] r_count;

    // Count register: a load starts a new segment and takes priority over stepping.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_start;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    // Equality end test: a segment ending at the top of the range never wraps.
    assign o_last  = (r_count == i_end);
    assign o_count = r_count;

endmodule

// File: rtl/draw_bounding_box.sv
// Waits for both edge-search results, latches the bounds and streams the
// rectangle outline as one pixel write per cycle, then pulses done.
module draw_bounding_box
    import bbox_pkg::*;
#(
    parameter int                 XSZ        = BBOX_XSZ,
    parameter int                 YSZ        = BBOX_YSZ,
    parameter int                 COLSZ      = BBOX_COLSZ,
    parameter logic [COLSZ-1:0]   BOX_COLOUR = COLSZ'(BBOX_COLOUR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             leftFound,
    input  logic             rightFound,
    input  logic [XSZ-1:0]   mostLeft,
    input  logic [XSZ-1:0]   mostRight,
    input  logic [YSZ-1:0]   mostTop,
    input  logic [YSZ-1:0]   mostBottom,
    output logic [XSZ-1:0]   x_out,
    output logic [YSZ-1:0]   y_out,
    output logic [COLSZ-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    state_t r_state, w_next_state;

    logic             r_l_seen, r_r_seen;
    logic [XSZ-1:0]   r_left, r_right;
    logic [YSZ-1:0]   r_top, r_bottom;
    logic             r_plot, r_busy, r_done;
    logic [COLSZ-1:0] r_colour;

    logic             w_state_busy;
    logic             w_l_ready, w_r_ready;
    logic [YSZ-1:0]   w_height, w_y_end, w_top_p1;
    logic             w_tall;
    logic             w_next_draw, w_next_busy;

    logic             w_x_load, w_x_en, w_x_last;
    logic [XSZ-1:0]   w_x_start, w_x_count;
    logic             w_y_load, w_y_en, w_y_last;
    logic [YSZ-1:0]   w_y_start, w_y_count;

    // Found pulses are only accepted outside the LATCH..RIGHT window.
    assign w_state_busy = (r_state inside {ST_LATCH, ST_TOP, ST_BOTTOM, ST_LEFT, ST_RIGHT});
    assign w_l_ready    = r_l_seen | (leftFound  & ~w_state_busy);
    assign w_r_ready    = r_r_seen | (rightFound & ~w_state_busy);

    // Vertical segment geometry; only used once T<=B has been established.
    assign w_height = r_bottom - r_top;
    assign w_tall   = (w_height >= YSZ'(2));
    assign w_top_p1 = r_top + YSZ'(1);
    assign w_y_end  = r_bottom - YSZ'(1);

    // Sticky found flags: cleared when the bounds are taken, otherwise set by pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_l_seen <= 1'b0;
            r_r_seen <= 1'b0;
        end else if (r_state == ST_LATCH) begin
            r_l_seen <= 1'b0;
            r_r_seen <= 1'b0;
        end else begin
            if (leftFound  && !w_state_busy) r_l_seen <= 1'b1;
            if (rightFound && !w_state_busy) r_r_seen <= 1'b1;
        end
    end

    // Bound latches, captured once per box in LATCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_left   <= '0;
            r_right  <= '0;
            r_top    <= '0;
            r_bottom <= '0;
        end else if (r_state == ST_LATCH) begin
            r_left   <= mostLeft;
            r_right  <= mostRight;
            r_top    <= mostTop;
            r_bottom <= mostBottom;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and counter control; each segment hands over on its last pixel.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        w_next_state = r_state;
        w_x_load     = 1'b0;
        w_x_start    = r_left;
        w_x_en       = 1'b0;
        w_y_load     = 1'b0;
        w_y_start    = w_top_p1;
        w_y_en       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_l_ready && w_r_ready) w_next_state = ST_LATCH;
            end
            ST_LATCH: begin
                // Bounds are taken from the inputs here as the latches load on this edge.
                if ((mostLeft > mostRight) || (mostTop > mostBottom)) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_TOP;
                    w_x_load     = 1'b1;
                    w_x_start    = mostLeft;
                    w_y_load     = 1'b1;
                    w_y_start    = mostTop;
                end
            end
            ST_TOP: begin
                w_x_en = 1'b1;
                if (w_x_last) begin
                    if (r_bottom != r_top) begin
                        w_next_state = ST_BOTTOM;
                        w_x_load     = 1'b1;
                        w_x_start    = r_left;
                        w_y_load     = 1'b1;
                        w_y_start    = r_bottom;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_BOTTOM: begin
                w_x_en = 1'b1;
                if (w_x_last) begin
                    if (w_tall) begin
                        w_next_state = ST_LEFT;
                        w_x_load     = 1'b1;
                        w_x_start    = r_left;
                        w_y_load     = 1'b1;
                        w_y_start    = w_top_p1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_LEFT: begin
                w_y_en = 1'b1;
                if (w_y_last) begin
                    if (r_left != r_right) begin
                        w_next_state = ST_RIGHT;
                        w_x_load     = 1'b1;
                        w_x_start    = r_right;
                        w_y_load     = 1'b1;
                        w_y_start    = w_top_p1;
                    end else begin
                        w_next_state = ST_DONE;
                    end
                end
            end
            ST_RIGHT: begin
                w_y_en = 1'b1;
                if (w_y_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_next_draw = (w_next_state inside {ST_TOP, ST_BOTTOM, ST_LEFT, ST_RIGHT});
    assign w_next_busy = w_next_draw | (w_next_state == ST_LATCH);

    // Output strobes registered from the next state so they align with the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_plot   <= 1'b0;
            r_colour <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_plot   <= w_next_draw;
            r_colour <= w_next_draw ? BOX_COLOUR : '0;
            r_busy   <= w_next_busy;
            r_done   <= (w_next_state == ST_DONE);
        end
    end

    // Horizontal position, reused by TOP, BOTTOM and the column select of LEFT/RIGHT.
    span_counter #(.W(XSZ)) u_x_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_x_load),
        .i_start (w_x_start),
        .i_en    (w_x_en),
        .i_end   (r_right),
        .o_count (w_x_count),
        .o_last  (w_x_last)
    );

    // Vertical position, reused by the row select of TOP/BOTTOM and LEFT, RIGHT.
    span_counter #(.W(YSZ)) u_y_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_y_load),
        .i_start (w_y_start),
        .i_en    (w_y_en),
        .i_end   (w_y_end),
        .o_count (w_y_count),
        .o_last  (w_y_last)
    );

    assign x_out  = w_x_count;
    assign y_out  = w_y_count;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
